// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 ROM streamer: byte-FSM state encoding and
// clock-count derivation of the WS2812B bit and latch timings.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH
    } state_t;

    // Nanoseconds to clock cycles, rounded to nearest.
    function automatic int unsigned ns_to_clks(input int unsigned clk_hz, input int unsigned ns);
        longint unsigned prod;
        prod = 64'(clk_hz) * 64'(ns) + 64'd500_000_000;
        return 32'(prod / 64'd1_000_000_000);
    endfunction

    function automatic int unsigned t0h_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 400);
    endfunction

    function automatic int unsigned t1h_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 800);
    endfunction

    function automatic int unsigned tbit_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 1250);
    endfunction

    function automatic int unsigned tlatch_clks(input int unsigned clk_hz, input int unsigned latch_us);
        return ns_to_clks(clk_hz, latch_us * 1000);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// WS2812B bit waveform generator: shifts one byte MSB first, each bit TBIT
// clocks, high for T1H (one) or T0H (zero) clocks. o_ready is high when idle
// or on the final clock of bit 0, so a load there continues with no gap.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_last_bit,
    output logic       o_dout
);
    localparam int unsigned TBIT = tbit_clks(CLK_HZ);
    localparam int unsigned T0H  = t0h_clks(CLK_HZ);
    localparam int unsigned T1H  = t1h_clks(CLK_HZ);
    localparam int unsigned CW   = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TBIT - 1);
    localparam logic [CW-1:0] HI1     = CW'(T1H);
    localparam logic [CW-1:0] HI0     = CW'(T0H);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_sr;
    logic          r_dout;

    logic          w_active_n;
    logic [CW-1:0] w_cnt_n;
    logic [2:0]    w_idx_n;
    logic [7:0]    w_sr_n;
    logic          w_dout_n;

    assign o_ready    = !r_active || (r_idx == 3'd0 && r_cnt == CNT_MAX);
    assign o_last_bit = r_active && (r_idx == 3'd0);
    assign o_dout     = r_dout;

    // Next bit/clock position; the line level is derived from the next state
    // so the output is a clean register.
    always_comb begin
        w_active_n = r_active;
        w_cnt_n    = r_cnt;
        w_idx_n    = r_idx;
        w_sr_n     = r_sr;
        if (i_load && o_ready) begin
            w_active_n = 1'b1;
            w_cnt_n    = '0;
            w_idx_n    = 3'd7;
            w_sr_n     = i_byte;
        end else if (r_active) begin
            if (r_cnt == CNT_MAX) begin
                w_cnt_n = '0;
                if (r_idx == 3'd0) begin
                    w_active_n = 1'b0;
                end else begin
                    w_idx_n = r_idx - 3'd1;
                end
            end else begin
                w_cnt_n = r_cnt + 1'b1;
            end
        end
        w_dout_n = w_active_n && (w_cnt_n < (w_sr_n[w_idx_n] ? HI1 : HI0));
    end

    // Bit counter, byte and output line registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_sr     <= '0;
            r_dout   <= 1'b0;
        end else begin
            r_active <= w_active_n;
            r_cnt    <= w_cnt_n;
            r_idx    <= w_idx_n;
            r_sr     <= w_sr_n;
            r_dout   <= w_dout_n;
        end
    end

endmodule

// File: rtl/ws2812_rom_streamer.sv
// Streams a frame of 3*NUM_LEDS GRB bytes from a synchronous ROM to a WS2812B
// chain, then holds the line low for the latch time.
// Define WS2812_LOOP_EN for continuous refresh: each latch end restarts the
// frame at the latched base address until reset.
module ws2812_rom_streamer
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27_000_000,
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned LATCH_US = 300
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [10:0] base_addr,
    output logic [10:0] rom_ad,
    output logic        rom_ce,
    output logic        rom_oce,
    input  logic [7:0]  rom_dout,
    output logic        led_dout,
    output logic        busy,
    output logic        done
);
    localparam int unsigned TLATCH = tlatch_clks(CLK_HZ, LATCH_US);
    localparam int unsigned TW     = (TLATCH > 1) ? $clog2(TLATCH) : 1;
    localparam logic [TW-1:0] TMR_MAX   = TW'(TLATCH - 1);
    localparam logic [11:0]   CNT_TOTAL = 12'(3 * NUM_LEDS);

    state_t        r_state;
    state_t        w_state_n;
    logic [10:0]   r_base;
    logic [11:0]   r_cnt;      // bytes fetched so far in this frame
    logic [7:0]    r_byte;
    logic          r_full;     // r_byte holds a fetched byte not yet handed to the bit generator
    logic [TW-1:0] r_timer;
    logic          r_busy;
    logic          r_done;

    logic          w_tx_load;
    logic          w_tx_ready;
    logic          w_tx_last_bit;
    logic          w_latch_end;

    assign rom_ce   = (r_state == FETCH);
    assign rom_oce  = rom_ce;
    assign rom_ad   = rom_ce ? (r_base + r_cnt[10:0]) : '0;
    assign busy     = r_busy;
    assign done     = r_done;

    ws2812_bit_tx #(
        .CLK_HZ(CLK_HZ)
    ) u_bit_tx (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tx_load),
        .i_byte     (r_byte),
        .o_ready    (w_tx_ready),
        .o_last_bit (w_tx_last_bit),
        .o_dout     (led_dout)
    );

    // Byte FSM: the next byte is fetched while bit 0 of the current one is on
    // the line and handed over on the bit generator's final clock.
    always_comb begin
        w_state_n   = r_state;
        w_tx_load   = 1'b0;
        w_latch_end = 1'b0;
        case (r_state)
            IDLE:  if (start) w_state_n = FETCH;
            FETCH: w_state_n = LOAD;
            LOAD:  w_state_n = SHIFT;
            SHIFT: begin
                if (r_full) begin
                    w_tx_load = w_tx_ready;
                end else if (r_cnt != CNT_TOTAL) begin
                    if (w_tx_last_bit) w_state_n = FETCH;
                end else if (w_tx_ready) begin
                    w_state_n = LATCH;
                end
            end
            LATCH: begin
                if (r_timer == TMR_MAX) begin
                    w_latch_end = 1'b1;
`ifdef WS2812_LOOP_EN
                    w_state_n = FETCH;
`else
                    w_state_n = IDLE;
`endif
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // State register and frame datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_full  <= 1'b0;
            r_timer <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_done  <= w_latch_end;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: r_cnt <= r_cnt + 12'd1;
                LOAD: begin
                    r_byte <= rom_dout;
                    r_full <= 1'b1;
                end
                SHIFT: if (w_tx_load) r_full <= 1'b0;
                LATCH: begin
                    if (w_latch_end) begin
                        r_timer <= '0;
                        r_cnt   <= '0;
`ifdef WS2812_LOOP_EN
                        r_busy  <= 1'b1;
`else
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rom_streamer.sv
// Scoreboard bench for ws2812_rom_streamer: expected ROM addresses and bit
// values are queued when a frame is started and consumed as fetches and line
// pulses appear. Build with WS2812_LOOP_EN to exercise continuous refresh.
module tb_ws2812_rom_streamer;
    localparam int unsigned CLK_HZ   = 27_000_000;
    localparam int unsigned NUM_LEDS = 1;
    localparam int unsigned LATCH_US = 300;
    localparam int BITS   = 24 * NUM_LEDS;
    localparam int TBIT   = 34;
    localparam int T0H    = 11;
    localparam int T1H    = 22;
    localparam int TLATCH = 8100;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [10:0] rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic [7:0]  rom_dout;
    logic        led_dout;
    logic        busy;
    logic        done;

    logic [7:0]  rom [0:2047];
    logic [10:0] exp_addr[$];
    bit          exp_bits[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;
    logic prev_led = 1'b0;
    int rise_cyc = 0;
    int bit_in_frame = 0;
    int exp_done_cyc = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rom_ce) rom_dout <= rom[rom_ad];

    ws2812_rom_streamer #(
        .CLK_HZ  (CLK_HZ),
        .NUM_LEDS(NUM_LEDS),
        .LATCH_US(LATCH_US)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .base_addr(base_addr),
        .rom_ad   (rom_ad),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_dout (rom_dout),
        .led_dout (led_dout),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Count done pulses independently of the scoreboard.
    always @(negedge clk) if (done === 1'b1) done_seen++;

    // Scoreboard monitor: ROM fetches and line waveform.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rom_ce || rom_oce) begin
                check("rom_ce", rom_ce, 1);
                check("rom_oce", rom_oce, 1);
                if (exp_addr.size() > 0) check("rom_ad", rom_ad, exp_addr.pop_front());
                else check("rom_fetch_unexpected", rom_ce, 0);
            end
            if (led_dout && !prev_led) begin
                if (bit_in_frame > 0) check("bit_period", cyc - rise_cyc, TBIT);
                rise_cyc = cyc;
                bit_in_frame++;
            end
            if (!led_dout && prev_led) begin
                if (exp_bits.size() > 0) check("high_time", cyc - rise_cyc, exp_bits.pop_front() ? T1H : T0H);
                else check("unexpected_bit", prev_led, 0);
                if (bit_in_frame == BITS) exp_done_cyc = rise_cyc + TBIT + TLATCH;
            end
            if (done) begin
                check("done_timing", cyc, exp_done_cyc);
                check("frame_bit_count", bit_in_frame, BITS);
                bit_in_frame = 0;
            end
        end
        prev_led = led_dout;
    end

    task automatic send_frame(input logic [10:0] base, input int frames);
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < 3 * NUM_LEDS; i++) begin
                logic [10:0] a;
                logic [7:0]  d;
                a = base + 11'(i);
                d = rom[a];
                exp_addr.push_back(a);
                for (int b = 7; b >= 0; b--) exp_bits.push_back(d[b]);
            end
        end
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = ~base;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_seen == d0 && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, done_seen - d0, 1);
    endtask

    task automatic flush();
        exp_addr.delete();
        exp_bits.delete();
        bit_in_frame = 0;
        exp_done_cyc = -1;
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hFF;
        rom[1] = 8'h00;
        rom[2] = 8'hAA;
        rom[2046] = 8'h3C;
        rom[2047] = 8'hC5;

        repeat (3) @(negedge clk);
        check("rst_led", led_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_ce", rom_ce, 0);
        check("rst_rom_oce", rom_oce, 0);
        check("rst_rom_ad", rom_ad, 0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

`ifdef WS2812_LOOP_EN
        // Continuous refresh: three frames queued; third is cut short by reset.
        d0 = done_seen;
        send_frame(11'd300, 3);
        check("busy_running", busy, 1);
        wait_done("loop_done1", d0);
        check("loop_busy1", busy, 1);
        wait_done("loop_done2", d0 + 1);
        check("loop_busy2", busy, 1);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("loop_rst_busy", busy, 0);
        check("loop_rst_led", led_dout, 0);
        reset_n = 1'b1;
        flush();
        check("loop_done_total", done_seen - d0, 2);
`else
        // Frame from address 0: FF, 00, AA.
        d0 = done_seen;
        send_frame(11'd0, 1);
        check("busy_running", busy, 1);
        wait_done("done_f1", d0);
        check("busy_after_done", busy, 0);
        check("bits_left_f1", exp_bits.size(), 0);
        check("addr_left_f1", exp_addr.size(), 0);
        repeat (5) @(negedge clk);

        // Address wrap 2046, 2047, 0.
        d0 = done_seen;
        send_frame(11'd2046, 1);
        wait_done("done_wrap", d0);
        check("addr_left_wrap", exp_addr.size(), 0);
        repeat (5) @(negedge clk);

        // Start re-pulsed with a different base while busy, including during latch.
        d0 = done_seen;
        send_frame(11'd0, 1);
        for (int n = 0; n < 2000; n++) begin
            start = (n == 3 || n == 20 || n == 400 || n == 1500);
            base_addr = 11'd77;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("done_repulse", d0);
        repeat (100) @(negedge clk);
        check("single_done", done_seen - d0, 1);
        check("busy_idle", busy, 0);

        // Reset during bit 5 of byte 2, then a fresh frame.
        d0 = done_seen;
        send_frame(11'd500, 1);
        begin
            int n = 0;
            while (bit_in_frame < 19 && n < BUDGET) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("reach_bit18", bit_in_frame, 19);
        end
        mon_en = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_led", led_dout, 0);
        check("abort_busy", busy, 0);
        reset_n = 1'b1;
        flush();
        @(negedge clk);
        mon_en = 1'b1;
        repeat (9000) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_led_idle", led_dout, 0);

        d0 = done_seen;
        send_frame(11'd0, 1);
        wait_done("done_after_abort", d0);
        check("bits_left_after_abort", exp_bits.size(), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rom_streamer.md
WS2812_ROM_STREAMER -- requirements
Module: ws2812_rom_streamer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_LEDS, default 64, LEDs per frame; frame length is 3*NUM_LEDS bytes, legal range 1..682.
REQ-003 SHALL have parameter LATCH_US, default 300, low time after a frame in microseconds.
REQ-004 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, a one-cycle request to send one frame.
REQ-007 SHALL have port base_addr, input, 11 bits, ROM byte address of the frame's first GRB byte, sampled on an accepted start.
REQ-008 SHALL have port rom_ad, output, 11 bits, ROM byte address.
REQ-009 SHALL have ports rom_ce and rom_oce, outputs, 1 bit each, ROM enables; rom_oce equals rom_ce.
REQ-010 SHALL have port rom_dout, input, 8 bits, ROM read data, valid on the cycle after rom_ce was high.
REQ-011 SHALL have port led_dout, output, 1 bit, the WS2812B serial line.
REQ-012 SHALL have ports busy and done, outputs, 1 bit each; busy is high while a frame or its latch is in progress, and done pulses for one cycle when the latch ends.

Function
REQ-013 SHALL derive these timings in clocks, each rounded to nearest: T0H=0.40 us (11 at 27 MHz), T1H=0.80 us (22), TBIT=1.25 us (34), TLATCH=LATCH_US us (8100).
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, SHIFT, LATCH.
REQ-015 SHALL in IDLE, on start, latch base_addr, clear the byte count, set busy, and go to FETCH; start is ignored in every other state.
REQ-016 SHALL in FETCH assert rom_ce for exactly one cycle with rom_ad set to base_addr plus the byte count, wrapping mod 2048, then go to LOAD.
REQ-017 SHALL in LOAD capture rom_dout into the shift register, then go to SHIFT.
REQ-018 SHALL in SHIFT send 8 bits MSB first, each TBIT clocks long; led_dout is high for the first T1H clocks of a 1 bit and the first T0H clocks of a 0 bit, and low for the rest of the bit.
REQ-019 SHALL prefetch the next byte while the current byte's bit 0 is being sent, so the bit stream between bytes has no gap: bit 0 of a byte is followed directly by bit 7 of the next.
REQ-020 SHALL after the last bit of byte 3*NUM_LEDS-1 hold led_dout low for TLATCH clocks in LATCH, then pulse done, clear busy, and go to IDLE.
REQ-021 SHALL keep led_dout low in IDLE and LATCH, and keep rom_ce low except during fetch cycles.

Reset
REQ-022 SHALL drive these values while reset_n is sampled low: state IDLE, led_dout 0, busy 0, done 0, rom_ce 0, rom_oce 0, rom_ad 0, all counters 0.
REQ-023 SHALL abort any frame on a reset in mid-frame, with led_dout low from the next edge; no done pulse is issued.

Configuration
REQ-024 SHALL use macro WS2812_LOOP_EN; when defined, the end of LATCH pulses done and returns to FETCH at the latched base_addr with busy held high (continuous refresh), and only reset stops it.
REQ-025 SHALL, when WS2812_LOOP_EN is not defined, behave per REQ-020 with one frame per start.

Structure
REQ-026 SHALL place the state enum and the timing-constant functions (which take CLK_HZ) in shared package ws2812_pkg.
REQ-027 SHALL put the bit waveform generator (bit counter plus the T0H/T1H compare) in sub-module ws2812_bit_tx, with a load/ready handshake to the byte FSM.

Verification
REQ-028 SHALL cover: NUM_LEDS=1, base_addr=0, ROM bytes FF,00,AA, one start -> 24 bits with high times 22x8, 11x8, then 22/11 alternating; each bit 34 clocks; done 8100 clocks after the last bit.
REQ-029 SHALL cover: base_addr=2046, NUM_LEDS=1 -> rom_ad sequence 2046, 2047, 0.
REQ-030 SHALL cover: start re-pulsed while busy=1 -> no effect on rom_ad or the waveform; exactly one done.
REQ-031 SHALL cover: reset_n low at bit 5 of byte 2 -> led_dout=0 and busy=0 next cycle, no done; a new start afterwards gives a correct full frame.
REQ-032 SHALL cover: a byte boundary -> the rising edge of bit 7 of byte n+1 is exactly 34 clocks after the rising edge of bit 0 of byte n.
REQ-033 SHALL cover, with WS2812_LOOP_EN defined: two consecutive frames -> done pulses twice, busy stays 1, and the second frame's first rom_ad equals base_addr.
